addr_decode_ctrl: RTL and testbench

Sequential, parametrised address decoder for the load/store path. It accepts one bus request at a time over a valid/ready handshake and decodes the address into a memory region code and an IO slot code. It holds the decoded select stable while a per-class wait-state counter runs, then returns a response with an error flag for unmapped addresses. It sits between the LSU and the memory/peripheral muxes and keeps a saturating count of unmapped accesses.

---
 rtl/addr_decode_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_addr_decode_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/addr_decode_ctrl.sv
// addr_decode_ctrl: sequential address decoder for the load/store path.
// Accepts one request at a time (valid/ready) and decodes addr[15:0] into a
// memory region code and an IO slot code. The decoded select is held during a
// per-class wait-state count, then a response is presented until rsp_ready.
// Unmapped requests respond with rsp_err and bump a saturating err_count.
// Ports:
//   clk, rst               clock (rising edge), async active-high reset
//   req_valid/req_ready    request handshake; req_addr, req_we request fields
//   sel_valid, sel_code,   latched decoded select for the current transaction
//   sel_io_code, sel_we
//   rsp_valid/rsp_ready    response handshake; rsp_err flags unmapped address
//   err_count              saturating count of unmapped requests
module addr_decode_ctrl #(
   parameter int unsigned ADDR_W      = 32,
   parameter logic [15:0] IMEM_BASE   = 16'h0000,
   parameter logic [15:0] DMEM_BASE   = 16'h2000,
   parameter logic [15:0] ROM_BASE    = 16'h4000,
   parameter int unsigned MEM_SZ_LOG2 = 13,
   parameter int unsigned ROM_SZ_LOG2 = 12,
   parameter logic [15:0] IO_LO_BASE  = 16'h7000,
   parameter int unsigned N_IO_LO     = 4,
   parameter logic [15:0] IO_HI_BASE  = 16'h7800,
   parameter int unsigned N_IO_HI     = 2,
   parameter int unsigned MEM_WAIT    = 0,
   parameter int unsigned ROM_WAIT    = 1,
   parameter int unsigned IO_WAIT     = 2,
   parameter int unsigned STRICT      = 1,
   parameter int unsigned IO_W        = $clog2(N_IO_LO + N_IO_HI + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_we,
   output logic              sel_valid,
   output logic [1:0]        sel_code,
   output logic [IO_W-1:0]   sel_io_code,
   output logic              sel_we,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_err,
   output logic [7:0]        err_count
);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              sel_valid_q, sel_valid_d;
   logic [1:0]        sel_code_q, sel_code_d;
   logic [IO_W-1:0]   sel_io_q, sel_io_d;
   logic              sel_we_q, sel_we_d;
   logic              rsp_err_q, rsp_err_d;
   logic [7:0]        err_count_q, err_count_d;

   // ---------------------------------------------------------------- decode
   logic [15:0]       a16;
   logic              upper_nz;
   logic [1:0]        dec_code;
   logic [IO_W-1:0]   dec_io;
   logic              dec_mapped;
   logic [7:0]        dec_wait;
   int                k_hi, k_lo;

   assign a16      = req_addr[15:0];
   assign upper_nz = |(req_addr >> 16);

   always_comb begin
      dec_code = 2'd0;
      dec_io   = '0;
      k_hi     = int'(a16[15:4]) - int'(IO_HI_BASE[15:4]);
      k_lo     = int'(a16[15:4]) - int'(IO_LO_BASE[15:4]);

      if ((a16 >> MEM_SZ_LOG2) == (IMEM_BASE >> MEM_SZ_LOG2)) begin
         dec_code = 2'd1;
      end else if ((a16 >> MEM_SZ_LOG2) == (DMEM_BASE >> MEM_SZ_LOG2)) begin
         dec_code = 2'd2;
      end else if ((a16 >> ROM_SZ_LOG2) == (ROM_BASE >> ROM_SZ_LOG2)) begin
         dec_code = 2'd3;
      end

      // Slot codes count down from the top of each block.
      if (k_hi >= 0 && k_hi < int'(N_IO_HI)) begin
         dec_io = IO_W'(int'(N_IO_HI) - k_hi);
      end else if (k_lo >= 0 && k_lo < int'(N_IO_LO)) begin
         dec_io = IO_W'(int'(N_IO_HI + N_IO_LO) - k_lo);
      end

      if (STRICT != 0 && upper_nz) begin
         dec_code = 2'd0;
         dec_io   = '0;
      end

      dec_mapped = (dec_code != 2'd0) || (dec_io != '0);

      // IO hit wins the wait class.
      if (dec_io != '0)          dec_wait = 8'(IO_WAIT);
      else if (dec_code == 2'd3) dec_wait = 8'(ROM_WAIT);
      else                       dec_wait = 8'(MEM_WAIT);
   end

   // ---------------------------------------------------------------- fsm
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= 8'd0;
         sel_valid_q <= 1'b0;
         sel_code_q  <= 2'd0;
         sel_io_q    <= '0;
         sel_we_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sel_valid_q <= sel_valid_d;
         sel_code_q  <= sel_code_d;
         sel_io_q    <= sel_io_d;
         sel_we_q    <= sel_we_d;
         rsp_err_q   <= rsp_err_d;
         err_count_q <= err_count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sel_valid_d = sel_valid_q;
      sel_code_d  = sel_code_q;
      sel_io_d    = sel_io_q;
      sel_we_d    = sel_we_q;
      rsp_err_d   = rsp_err_q;
      err_count_d = err_count_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               sel_code_d  = dec_code;
               sel_io_d    = dec_io;
               sel_we_d    = req_we;
               sel_valid_d = dec_mapped;
               rsp_err_d   = !dec_mapped;
               if (!dec_mapped) begin
                  if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                  state_d = StResp;
               end else if (dec_wait == 8'd0) begin
                  state_d = StResp;
               end else begin
                  cnt_d   = dec_wait;
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (cnt_q == 8'd1) begin
               cnt_d   = 8'd0;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               sel_valid_d = 1'b0;
               sel_code_d  = 2'd0;
               sel_io_d    = '0;
               sel_we_d    = 1'b0;
               rsp_err_d   = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign req_ready   = (state_q == StIdle);
   assign rsp_valid   = (state_q == StResp);
   assign sel_valid   = sel_valid_q;
   assign sel_code    = sel_code_q;
   assign sel_io_code = sel_io_q;
   assign sel_we      = sel_we_q;
   assign rsp_err     = rsp_err_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_addr_decode_ctrl.sv
module tb_addr_decode_ctrl;

   localparam int IO_W = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid, req_ready, req_we;
   logic [31:0]     req_addr;
   logic            sel_valid, sel_we, rsp_valid, rsp_ready, rsp_err;
   logic [1:0]      sel_code;
   logic [IO_W-1:0] sel_io_code;
   logic [7:0]      err_count;

   // Second instance with STRICT=0, driven separately.
   logic            v0, rdy0, sv0, we0, rv0, err0;
   logic [31:0]     a0;
   logic [1:0]      code0;
   logic [IO_W-1:0] io0;
   logic [7:0]      ec0;

   int checks   = 0;
   int failures = 0;
   int exp_errc = 0;

   always #5 clk = ~clk;

   addr_decode_ctrl #(.ADDR_W(32), .STRICT(1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_we(req_we), .sel_valid(sel_valid), .sel_code(sel_code),
      .sel_io_code(sel_io_code), .sel_we(sel_we), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_err(rsp_err), .err_count(err_count)
   );

   addr_decode_ctrl #(.ADDR_W(32), .STRICT(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0),
      .req_addr(a0), .req_we(1'b0), .sel_valid(sv0), .sel_code(code0),
      .sel_io_code(io0), .sel_we(we0), .rsp_valid(rv0),
      .rsp_ready(1'b1), .rsp_err(err0), .err_count(ec0)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference map computed from address ranges.
   task automatic ref_decode(input logic [31:0] addr, input bit strict,
                             output int code, output int io, output int err,
                             output int lat);
      int a;
      a    = int'(addr[15:0]);
      code = 0;
      io   = 0;
      if (a < 'h2000)                    code = 1;
      else if (a < 'h4000)               code = 2;
      else if (a < 'h5000)               code = 3;
      for (int k = 0; k < 2; k++)
         if (a >= 'h7800 + 16 * k && a < 'h7810 + 16 * k) io = 2 - k;
      for (int k = 0; k < 4; k++)
         if (io == 0 && a >= 'h7000 + 16 * k && a < 'h7010 + 16 * k) io = 6 - k;
      if (strict && addr[31:16] != 16'd0) begin
         code = 0;
         io   = 0;
      end
      err = (code == 0 && io == 0) ? 1 : 0;
      lat = err ? 0 : (io != 0) ? 2 : (code == 3) ? 1 : 0;
   endtask

   task automatic run_txn(input logic [31:0] a, input logic we, input int hold,
                          input int ecode, input int eio, input int eerr, input int elat,
                          input bit full);
      int n;
      chk("req_ready_idle", int'(req_ready), 1);
      req_valid = 1'b1;
      req_addr  = a;
      req_we    = we;
      rsp_ready = 1'b0;
      step();
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_we    = ~we;
      if (eerr != 0) exp_errc = (exp_errc < 255) ? exp_errc + 1 : 255;
      n = 0;
      while (!rsp_valid && n < 20) begin
         if (full) begin
            chk("wait_sel_code", int'(sel_code), ecode);
            chk("wait_sel_io", int'(sel_io_code), eio);
            chk("wait_req_ready", int'(req_ready), 0);
         end
         step();
         n++;
      end
      chk("latency", n, elat);
      if (full) begin
         for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
               req_valid = 1'b1;
               req_addr  = $urandom;
            end
            chk("rsp_valid", int'(rsp_valid), 1);
            chk("req_ready_resp", int'(req_ready), 0);
            chk("sel_code", int'(sel_code), ecode);
            chk("sel_io_code", int'(sel_io_code), eio);
            chk("sel_valid", int'(sel_valid), 1 - eerr);
            chk("sel_we", int'(sel_we), int'(we));
            chk("rsp_err", int'(rsp_err), eerr);
            chk("err_count", int'(err_count), exp_errc);
            if (h < hold) step();
         end
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      if (full) begin
         chk("post_rsp_valid", int'(rsp_valid), 0);
         chk("post_req_ready", int'(req_ready), 1);
         chk("post_sel_valid", int'(sel_valid), 0);
         chk("post_sel_code", int'(sel_code), 0);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        we;
      int          hold;
      int          code;
      int          io;
      int          err;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, io, e, l, sel;
      logic [31:0] ra;

      vecs = '{
         '{32'h0000_0004, 1'b0, 0, 1, 0, 0, 0},
         '{32'h0000_2FFC, 1'b1, 0, 2, 0, 0, 0},
         '{32'h0000_4010, 1'b0, 0, 3, 0, 0, 1},
         '{32'h0000_7810, 1'b1, 0, 0, 1, 0, 2},
         '{32'h0000_7030, 1'b0, 0, 0, 3, 0, 2},
         '{32'h0000_7000, 1'b1, 0, 0, 6, 0, 2},
         '{32'h0000_5000, 1'b0, 0, 0, 0, 1, 0},
         '{32'h0001_0000, 1'b1, 0, 0, 0, 1, 0},
         '{32'h0000_4000, 1'b0, 4, 3, 0, 0, 1},
         '{32'h0000_7800, 1'b1, 2, 0, 2, 0, 2},
         '{32'h0000_7040, 1'b0, 0, 0, 0, 1, 0},
         '{32'h0000_1FFF, 1'b1, 4, 1, 0, 0, 0}
      };

      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; rsp_ready = 1'b0;
      v0 = 1'b0; a0 = '0;
      step(); step();
      chk("rst_req_ready", int'(req_ready), 1);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_sel_valid", int'(sel_valid), 0);
      chk("rst_err_count", int'(err_count), 0);
      rst = 1'b0;
      step();

      foreach (vecs[i])
         run_txn(vecs[i].addr, vecs[i].we, vecs[i].hold, vecs[i].code, vecs[i].io,
                 vecs[i].err, vecs[i].lat, 1'b1);

      // Non-strict decode of an address with upper bits set.
      v0 = 1'b1; a0 = 32'h0001_0000;
      step();
      v0 = 1'b0; a0 = 32'hFFFF_FFFF;
      chk("nonstrict_rsp_valid", int'(rv0), 1);
      chk("nonstrict_code", int'(code0), 1);
      chk("nonstrict_err", int'(err0), 0);
      step();

      // Randomised traffic against the range model.
      for (int t = 0; t < 80; t++) begin
         sel = $urandom_range(0, 3);
         ra  = $urandom;
         case (sel)
            0: ra = {16'h0, ra[15:0]};
            1: ra = {16'h0, 16'h7000 + 16'(ra[8:0])};
            2: ra = {16'h0, 16'h7800 + 16'(ra[6:0])};
            default: ;
         endcase
         ref_decode(ra, 1'b1, c, io, e, l);
         run_txn(ra, ra[20], int'($urandom_range(0, 2)), c, io, e, l, 1'b1);
      end

      // Reset while waiting on an IO access.
      req_valid = 1'b1; req_addr = 32'h0000_7800; req_we = 1'b1;
      step();
      req_valid = 1'b0;
      chk("pre_rst_sel_valid", int'(sel_valid), 1);
      rst = 1'b1;
      #1;
      chk("arst_sel_valid", int'(sel_valid), 0);
      chk("arst_sel_code", int'(sel_code), 0);
      chk("arst_sel_io", int'(sel_io_code), 0);
      chk("arst_sel_we", int'(sel_we), 0);
      chk("arst_req_ready", int'(req_ready), 1);
      chk("arst_err_count", int'(err_count), 0);
      #2;
      rst = 1'b0;
      exp_errc = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("post_rst_no_rsp", int'(rsp_valid), 0);
      end

      // Saturation of the unmapped counter.
      for (int i = 0; i < 260; i++)
         run_txn(32'h0000_5000, 1'b0, 0, 0, 0, 1, 0, 1'b0);
      chk("err_count_sat", int'(err_count), 255);
      run_txn(32'h0000_5000, 1'b0, 0, 0, 0, 1, 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
